// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction-fetch controller. It owns the architectural PC and runs one
// fetch at a time over a request/grant/response instruction-memory port. Each
// fetched instruction is then offered to decode. Branch/jump redirects are
// applied, and a fetch already in flight is discarded.
//
// Handshakes:
//   imem_req/imem_gnt : the request is held, with a stable address, until gnt.
//                       A redirect may change the address before gnt.
//   imem_rvalid       : exactly one response per grant, at least one cycle
//                       after the granting cycle.
//   if_valid/if_ready : a transfer happens on a cycle where both are 1.
//                       if_pc/if_instr stay stable while if_valid=1 and
//                       if_ready=0.
//
// Ports:
//   clk, reset (async, active-low)
//   redirect_valid, redirect_pc[31:0]            : redirect from execute
//   imem_req, imem_addr[31:0]                     : fetch request
//   imem_gnt, imem_rvalid, imem_rdata[31:0]       : memory grant/response
//   if_valid, if_ready, if_pc, if_instr, if_pc_plus4 : decode interface
//   dbg_state[1:0]                                : FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 HOLD)
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] if_pc_q, if_instr_q;
  logic        capture;
  logic [31:0] redirect_tgt;

  // Masking keeps every bit of redirect_pc in use and forces word alignment.
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = redirect_tgt;
      end
      S_REQ: begin
        // A granted request always produces a response. Under a redirect,
        // that response must be discarded when it arrives.
        if (imem_gnt) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
        if (redirect_valid) pc_d = redirect_tgt;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid || drop_q) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = S_HOLD;
            capture = 1'b1;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
        if (redirect_valid) pc_d = redirect_tgt;
      end
      S_HOLD: begin
        // A redirect wins over a simultaneous accept, so there is no +4 step.
        if (redirect_valid) begin
          state_d = S_REQ;
          pc_d    = redirect_tgt;
        end else if (if_ready) begin
          state_d = S_REQ;
          pc_d    = pc_q + 32'd4;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      if (capture) begin
        if_pc_q    <= pc_q;
        if_instr_q <= imem_rdata;
      end
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign if_valid    = (state_q == S_HOLD);
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc_plus4 = if_pc_q + 32'd4;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer.
// A table of fetch transactions sets the grant, response and accept stalls and
// the expected PC. Each transaction is driven through a memory/decode driver
// task, and a scoreboard queue holds the expected {pc, instr} pairs. These are
// followed by hand-written redirect, wrap and reset sequences.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic [1:0]  dbg_state;

  fetch_sequencer #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    int          gnt_wait;
    int          rv_wait;
    int          rdy_wait;
    logic [31:0] instr;
    logic [31:0] exp_pc;
  } vec_t;

  // ---------------- driver ----------------
  // Starts at a negedge. It waits for the request, grants it after gnt_wait
  // cycles and returns the response rv_wait cycles later. Then it checks the
  // presented instruction, stalls decode for rdy_wait cycles and, if accept
  // is set, accepts the instruction.
  task automatic do_fetch(input vec_t v, input bit accept);
    int n;
    logic [63:0] e;
    logic [31:0] e_pc, e_instr, e_plus4;
    n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    check("req_addr", imem_addr, v.exp_pc);
    exp_q.push_back({v.exp_pc, v.instr});
    for (int i = 0; i < v.gnt_wait; i++) begin
      imem_gnt = 1'b0;
      @(negedge clk);
      check("stall_req", {31'b0, imem_req}, 32'd1);
      check("stall_addr", imem_addr, v.exp_pc);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("wait_noreq", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < v.rv_wait; i++) begin
      @(negedge clk);
      check("wait_state", {30'b0, dbg_state}, 32'd2);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = v.instr;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    check("hold_valid", {31'b0, if_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL sb_empty at %0t: got empty queue expected entry", $time);
    end else begin
      e       = exp_q.pop_front();
      e_pc    = e[63:32];
      e_instr = e[31:0];
      e_plus4 = e_pc + 32'd4;
      check("if_pc", if_pc, e_pc);
      check("if_instr", if_instr, e_instr);
      check("if_pc_plus4", if_pc_plus4, e_plus4);
      for (int i = 0; i < v.rdy_wait; i++) begin
        if_ready = 1'b0;
        @(negedge clk);
        check("stall_valid", {31'b0, if_valid}, 32'd1);
        check("stall_pc", if_pc, e_pc);
        check("stall_instr", if_instr, e_instr);
        check("stall_noreq", {31'b0, imem_req}, 32'd0);
      end
    end
    if (accept) begin
      if_ready = 1'b1;
      @(negedge clk);
      if_ready = 1'b0;
    end
  endtask

  // ---------------- test ----------------
  vec_t tbl[5];
  vec_t v;

  initial begin
    tbl[0] = '{0, 0, 0, 32'h0050_0093, 32'h0000_0000};
    tbl[1] = '{0, 0, 5, 32'h0010_0113, 32'h0000_0004};
    tbl[2] = '{4, 0, 0, 32'h0020_8193, 32'h0000_0008};
    tbl[3] = '{0, 2, 0, 32'h4030_0233, 32'h0000_000C};
    tbl[4] = '{1, 1, 1, 32'hFE00_0EE3, 32'h0000_0010};

    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_pc", if_pc, RESET_PC);
    check("rst_instr", if_instr, NOP_INSTR);
    check("rst_plus4", if_pc_plus4, RESET_PC + 32'd4);
    reset = 1'b1;

    // Sequential fetches with assorted stalls.
    for (int k = 0; k < 5; k++) do_fetch(tbl[k], 1'b1);

    // Redirect while waiting for a response: that response is discarded.
    check("pre_redir_addr", imem_addr, 32'h0000_0014);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redir_wait_state", {30'b0, dbg_state}, 32'd2);
    check("redir_wait_valid", {31'b0, if_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("drop_valid", {31'b0, if_valid}, 32'd0);
    check("drop_req", {31'b0, imem_req}, 32'd1);
    check("drop_addr", imem_addr, 32'h0000_0100);
    v = '{0, 0, 0, 32'h0000_0517, 32'h0000_0100};
    do_fetch(v, 1'b1);

    // Redirect of an ungranted request, then wrap around at 2^32.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redir_req_addr", imem_addr, 32'hFFFF_FFFC);
    v = '{0, 0, 0, 32'h0000_006F, 32'hFFFF_FFFC};
    do_fetch(v, 1'b1);
    v = '{0, 0, 0, 32'h0080_00E7, 32'h0000_0000};
    do_fetch(v, 1'b0);

    // Redirect together with if_ready in HOLD: no +4 step.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    if_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    check("redir_hold_valid", {31'b0, if_valid}, 32'd0);
    check("redir_hold_req", {31'b0, imem_req}, 32'd1);
    check("redir_hold_addr", imem_addr, 32'h0000_0200);
    v = '{0, 0, 0, 32'h00C0_0293, 32'h0000_0200};
    do_fetch(v, 1'b1);

    // Reset in WAIT, then a stale response arrives in REQ after release.
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("pre_rst_wait", {30'b0, dbg_state}, 32'd2);
    reset = 1'b0;
    #1;
    check("mid_rst_state", {30'b0, dbg_state}, 32'd0);
    check("mid_rst_addr", imem_addr, RESET_PC);
    check("mid_rst_pc", if_pc, RESET_PC);
    check("mid_rst_instr", if_instr, NOP_INSTR);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("stale_req", {31'b0, imem_req}, 32'd1);
    check("stale_addr", imem_addr, RESET_PC);
    check("stale_valid", {31'b0, if_valid}, 32'd0);
    check("stale_pc", if_pc, RESET_PC);
    check("stale_instr", if_instr, NOP_INSTR);
    v = '{1, 0, 0, 32'h0050_0093, RESET_PC};
    do_fetch(v, 1'b1);

    check("sb_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
